// File: rtl/lstm_sa_pkg.sv
`default_nettype none
// ============================================================================
// lstm_sa_pkg : shared types for the LSTM systolic-array delay logic
// Rev 1.0
// ============================================================================
package lstm_sa_pkg;

    // Widest request address any delay element carries; narrower banks zero-extend.
    localparam int MAX_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } delay_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  cs;
        logic [MAX_ADDR_W-1:0] addr;
    } sa_req_t;

    function automatic int addr_w(input int feature_bits);
        return 2 * feature_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_stage.sv
`default_nettype none
// ============================================================================
// delay_stage : one registered request slot with hold and clear
// Rev 1.0
// ============================================================================
module delay_stage
    import lstm_sa_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold,
    input  logic    clear,
    input  sa_req_t d,
    output sa_req_t q
);

    // Clear drops the request but leaves the address bits where they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q.valid <= 1'b0;
            q.cs    <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/skew_delay_bank.sv
`default_nettype none
// ============================================================================
// skew_delay_bank : per-PE-row skewed/aligned copies of a broadcast request
// Rev 1.0
// ============================================================================
module skew_delay_bank
    import lstm_sa_pkg::*;
#(
    parameter  int FEATURE_BITS = 4,
    parameter  int N_CH         = 4,
    localparam int ADDR_W       = addr_w(FEATURE_BITS)
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address_in,
    input  logic                     enable_in,
    input  logic                     cs_in,
    input  logic                     mode_in,
    input  logic                     stall_in,
    input  logic                     flush_in,
    output logic [N_CH*ADDR_W-1:0]   address_out,
    output logic [N_CH-1:0]          enable_out,
    output logic [N_CH-1:0]          cs_out,
    output logic                     busy_out,
    output logic                     mode_out
);

    sa_req_t         in_req;
    sa_req_t         stage_q [N_CH];
    sa_req_t         tap     [N_CH];
    logic [N_CH-2:0] early_valid;
    logic [N_CH-1:0] unused_tap;
    delay_state_t    state_q;
    delay_state_t    state_d;
    logic            mode_q;

    always_comb begin
        in_req                    = '0;
        in_req.valid              = enable_in;
        in_req.cs                 = cs_in;
        in_req.addr[ADDR_W-1:0]   = address_in;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chain
        if (k == 0) begin : g_head
            delay_stage u_stage (
                .clk   (sys_clk),
                .rst_n (reset_n),
                .hold  (stall_in),
                .clear (flush_in),
                .d     (in_req),
                .q     (stage_q[k])
            );
        end else begin : g_body
            delay_stage u_stage (
                .clk   (sys_clk),
                .rst_n (reset_n),
                .hold  (stall_in),
                .clear (flush_in),
                .d     (stage_q[k-1]),
                .q     (stage_q[k])
            );
        end

        assign tap[k]        = mode_q ? stage_q[N_CH-1] : stage_q[k];
        assign enable_out[k] = tap[k].valid & ~stall_in;
        assign cs_out[k]     = tap[k].cs & enable_out[k];
        assign address_out[k*ADDR_W +: ADDR_W] = tap[k].addr[ADDR_W-1:0];
        assign unused_tap[k] = ^tap[k];
    end

    for (genvar k = 0; k < N_CH - 1; k++) begin : g_early
        assign early_valid[k] = stage_q[k].valid;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                mode_q <= mode_in;
            end
        end
    end

    // DRAIN ends once the last in-flight request has reached the final stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_in && !stall_in && !flush_in) state_d = RUN;
            end
            RUN: begin
                if (flush_in)                       state_d = IDLE;
                else if (!stall_in && !enable_in)   state_d = DRAIN;
            end
            DRAIN: begin
                if (flush_in)                       state_d = IDLE;
                else if (!stall_in) begin
                    if (enable_in)                  state_d = RUN;
                    else if (~|early_valid)         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_out = (state_q != IDLE);
    assign mode_out = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_skew_delay_bank.sv
`default_nettype none
// ============================================================================
// tb_skew_delay_bank : directed vector bench for skew_delay_bank (4 x 8-bit)
// Rev 1.0
// ============================================================================
module tb_skew_delay_bank;

    logic        clk;
    logic        reset_n;
    logic [7:0]  address_in;
    logic        enable_in;
    logic        cs_in;
    logic        mode_in;
    logic        stall_in;
    logic        flush_in;
    logic [31:0] address_out;
    logic [3:0]  enable_out;
    logic [3:0]  cs_out;
    logic        busy_out;
    logic        mode_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        cs;
        logic [7:0]  addr;
        logic        mode;
        logic        stall;
        logic        flush;
        logic [3:0]  exp_en;
        logic [3:0]  exp_cs;
        logic [31:0] exp_addr;
        logic        exp_busy;
        logic        exp_mode;
    } vec_t;

    vec_t vecs[$];

    skew_delay_bank #(.FEATURE_BITS(4), .N_CH(4)) dut (
        .sys_clk     (clk),
        .reset_n     (reset_n),
        .address_in  (address_in),
        .enable_in   (enable_in),
        .cs_in       (cs_in),
        .mode_in     (mode_in),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .address_out (address_out),
        .enable_out  (enable_out),
        .cs_out      (cs_out),
        .busy_out    (busy_out),
        .mode_out    (mode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [3:0] een, input logic [3:0] ecs,
                         input logic [31:0] eaddr, input logic ebusy, input logic emode);
        checks++;
        if (enable_out !== een || cs_out !== ecs || address_out !== eaddr ||
            busy_out !== ebusy || mode_out !== emode) begin
            errors++;
            $display("FAIL %s: got en=%b cs=%b addr=%h busy=%b mode=%b, want en=%b cs=%b addr=%h busy=%b mode=%b",
                     nm, enable_out, cs_out, address_out, busy_out, mode_out,
                     een, ecs, eaddr, ebusy, emode);
        end
    endtask

    task automatic drive(input logic en, input logic cs, input logic [7:0] a,
                         input logic md, input logic st, input logic fl);
        enable_in  = en;
        cs_in      = cs;
        address_in = a;
        mode_in    = md;
        stall_in   = st;
        flush_in   = fl;
    endtask

    // Apply inputs, take one edge, then compare 1 ns after it.
    task automatic run(input string nm, input logic en, input logic cs, input logic [7:0] a,
                       input logic md, input logic st, input logic fl,
                       input logic [3:0] een, input logic [3:0] ecs, input logic [31:0] eaddr,
                       input logic ebusy, input logic emode);
        drive(en, cs, a, md, st, fl);
        @(posedge clk);
        #1;
        check(nm, een, ecs, eaddr, ebusy, emode);
    endtask

    initial begin
        // Skew stream 0x00..0x09, then drain
        vecs.push_back('{1, 1, 8'h00, 0, 0, 0, 4'h1, 4'h1, 32'h00000000, 1, 0});
        vecs.push_back('{1, 1, 8'h01, 0, 0, 0, 4'h3, 4'h3, 32'h00000001, 1, 0});
        vecs.push_back('{1, 1, 8'h02, 0, 0, 0, 4'h7, 4'h7, 32'h00000102, 1, 0});
        vecs.push_back('{1, 1, 8'h03, 0, 0, 0, 4'hF, 4'hF, 32'h00010203, 1, 0});
        vecs.push_back('{1, 1, 8'h04, 0, 0, 0, 4'hF, 4'hF, 32'h01020304, 1, 0});
        vecs.push_back('{1, 1, 8'h05, 0, 0, 0, 4'hF, 4'hF, 32'h02030405, 1, 0});
        vecs.push_back('{1, 1, 8'h06, 0, 0, 0, 4'hF, 4'hF, 32'h03040506, 1, 0});
        vecs.push_back('{1, 1, 8'h07, 0, 0, 0, 4'hF, 4'hF, 32'h04050607, 1, 0});
        vecs.push_back('{1, 1, 8'h08, 0, 0, 0, 4'hF, 4'hF, 32'h05060708, 1, 0});
        vecs.push_back('{1, 1, 8'h09, 0, 0, 0, 4'hF, 4'hF, 32'h06070809, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'hE, 4'hE, 32'h07080900, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'hC, 4'hC, 32'h08090000, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'h8, 4'h8, 32'h09000000, 1, 0});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0});
        // Aligned mode: 0x05 (cs=0) then 0x06 (cs=1); mode stays latched until IDLE
        vecs.push_back('{1, 0, 8'h05, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1});
        vecs.push_back('{1, 1, 8'h06, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1});
        vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1});
        vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 4'hF, 4'h0, 32'h05050505, 1, 1});
        vecs.push_back('{0, 0, 8'h00, 1, 0, 0, 4'hF, 4'hF, 32'h06060606, 1, 1});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 1});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0});

        reset_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 0);
        #3;
        check("reset_state", 4'h0, 4'h0, 32'h0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run($sformatf("vec%0d", i), vecs[i].en, vecs[i].cs, vecs[i].addr, vecs[i].mode,
                vecs[i].stall, vecs[i].flush, vecs[i].exp_en, vecs[i].exp_cs,
                vecs[i].exp_addr, vecs[i].exp_busy, vecs[i].exp_mode);
        end

        // Two-cycle stall after the third request; 0x99 offered during the stall is lost
        run("st0", 1, 1, 8'h11, 0, 0, 0, 4'h1, 4'h1, 32'h00000011, 1, 0);
        run("st1", 1, 1, 8'h12, 0, 0, 0, 4'h3, 4'h3, 32'h00001112, 1, 0);
        run("st2", 1, 1, 8'h13, 0, 0, 0, 4'h7, 4'h7, 32'h00111213, 1, 0);
        drive(1, 1, 8'h99, 0, 1, 0);
        #1;
        check("st_mask", 4'h0, 4'h0, 32'h00111213, 1, 0);
        run("st3", 1, 1, 8'h99, 0, 1, 0, 4'h0, 4'h0, 32'h00111213, 1, 0);
        run("st4", 1, 1, 8'h99, 0, 1, 0, 4'h0, 4'h0, 32'h00111213, 1, 0);
        run("st5", 1, 1, 8'h14, 0, 0, 0, 4'hF, 4'hF, 32'h11121314, 1, 0);
        run("st6", 1, 1, 8'h15, 0, 0, 0, 4'hF, 4'hF, 32'h12131415, 1, 0);
        run("st7", 0, 0, 8'h00, 0, 0, 0, 4'hE, 4'hE, 32'h13141500, 1, 0);
        run("st8", 0, 0, 8'h00, 0, 0, 0, 4'hC, 4'hC, 32'h14150000, 1, 0);
        run("st9", 0, 0, 8'h00, 0, 0, 0, 4'h8, 4'h8, 32'h15000000, 1, 0);
        run("st10", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0);

        // Flush together with stall and a new request, 3 requests in flight
        run("fl0", 1, 1, 8'h21, 0, 0, 0, 4'h1, 4'h1, 32'h00000021, 1, 0);
        run("fl1", 1, 1, 8'h22, 0, 0, 0, 4'h3, 4'h3, 32'h00002122, 1, 0);
        run("fl2", 1, 1, 8'h23, 0, 0, 0, 4'h7, 4'h7, 32'h00212223, 1, 0);
        run("fl3", 1, 1, 8'h24, 0, 1, 1, 4'h0, 4'h0, 32'h00212223, 0, 0);
        run("fl4", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h21222300, 0, 0);
        run("fl5", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h22230000, 0, 0);
        run("fl6", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h23000000, 0, 0);
        run("fl7", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0);

        // mode_in toggled mid-stream takes effect only after the bank drains
        run("md0", 1, 1, 8'h31, 0, 0, 0, 4'h1, 4'h1, 32'h00000031, 1, 0);
        run("md1", 1, 1, 8'h32, 1, 0, 0, 4'h3, 4'h3, 32'h00003132, 1, 0);
        run("md2", 0, 0, 8'h00, 1, 0, 0, 4'h6, 4'h6, 32'h00313200, 1, 0);
        run("md3", 0, 0, 8'h00, 1, 0, 0, 4'hC, 4'hC, 32'h31320000, 1, 0);
        run("md4", 0, 0, 8'h00, 1, 0, 0, 4'h8, 4'h8, 32'h32000000, 1, 0);
        run("md5", 0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0);
        run("md6", 0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 1);
        run("md7", 1, 1, 8'h33, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1);
        run("md8", 0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1);
        run("md9", 0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 1, 1);
        run("md10", 0, 0, 8'h00, 1, 0, 0, 4'hF, 4'hF, 32'h33333333, 1, 1);
        run("md11", 0, 0, 8'h00, 1, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 1);
        run("md12", 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 32'h00000000, 0, 0);

        // Asynchronous reset between edges, then a fresh request
        run("rs0", 1, 1, 8'h41, 0, 0, 0, 4'h1, 4'h1, 32'h00000041, 1, 0);
        run("rs1", 1, 1, 8'h42, 0, 0, 0, 4'h3, 4'h3, 32'h00004142, 1, 0);
        drive(0, 0, 8'h00, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        check("rs_async", 4'h0, 4'h0, 32'h00000000, 0, 0);
        #1;
        reset_n = 1'b1;
        #1;
        check("rs_release", 4'h0, 4'h0, 32'h00000000, 0, 0);
        run("rs2", 1, 1, 8'h0A, 0, 0, 0, 4'h1, 4'h1, 32'h0000000A, 1, 0);
        run("rs3", 0, 0, 8'h00, 0, 0, 0, 4'h2, 4'h2, 32'h00000A00, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skew_delay_bank.md
# skew_delay_bank

Multi-channel systolic skew generator for the LSTM accelerator's systolic array. One broadcast request (address, enable, chip-select) enters; N_CH per-PE-row copies leave, each delayed by a channel-dependent number of cycles so that PE row p sees the request exactly when its operands arrive. It generalises the single-tap delay element to a parametrised bank with skew/aligned modes, stall, flush, and drain tracking.

## Interface
- FEATURE_BITS, 4, feature index width; address width ADDR_W = 2*FEATURE_BITS
- N_CH, 4, number of output channels (PE rows), >= 2; also the shift-chain depth
- sys_clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- address_in  in  ADDR_W  broadcast request address
- enable_in  in  1  request valid
- cs_in  in  1  chip-select accompanying the request
- mode_in  in  1  0 = skew (channel p delayed p+1 cycles), 1 = aligned (all channels delayed N_CH cycles)
- stall_in  in  1  freeze the chain
- flush_in  in  1  discard all in-flight requests
- address_out  out  N_CH*ADDR_W  channel p at bits [p*ADDR_W +: ADDR_W]
- enable_out  out  N_CH  per-channel valid
- cs_out  out  N_CH  per-channel chip-select
- busy_out  out  1  high while any stage holds a valid request
- mode_out  out  1  currently latched mode

## Operation
- The chain has N_CH stages. Each stage holds {valid, cs, addr}. Stage 0 loads the inputs, and stage k loads stage k-1 on every non-stalled cycle.
- Skew mode: channel p taps stage p. Aligned mode: every channel taps stage N_CH-1.
- enable_out[p] = tapped valid AND NOT stall_in. cs_out[p] = tapped cs AND enable_out[p]. address_out is the tapped address and is unmasked, so it holds its value during a stall.
- While stall_in=1, all stages hold and inputs are ignored. A request presented during a stall is lost; the upstream block must hold off.
- flush_in=1 clears every valid and cs bit at the next edge. Addresses are left untouched. flush has priority over stall and over any new input on the same cycle.
- State machine, state_q:
  - IDLE: all valid bits are 0. mode_in is latched into mode_q every IDLE cycle. Go to RUN on enable_in && !stall_in && !flush_in.
  - RUN: enable_in seen in the last cycle. Go to DRAIN when enable_in=0 on a non-stalled cycle. Go to IDLE on flush.
  - DRAIN: no new input, valid bits still present. Go to RUN on enable_in. Go to IDLE when the only remaining valid bit is in stage N_CH-1 and the cycle is not stalled, or on flush.
- mode_q is frozen outside IDLE. A mode_in change mid-stream has no effect until the bank drains.
- busy_out = (state_q != IDLE).

## Timing
- Reset values: all stage valid, cs and address bits = 0, so every output is 0. state_q=IDLE, mode_q=0, busy_out=0, mode_out=0.
- Reset takes effect immediately (asynchronously) and may occur mid-stream. It discards in-flight requests with no partial outputs.
- Latency, counted in non-stalled edges, from an input sampled at edge t:
  - Skew mode: channel p is valid in the cycle after edge t+p, i.e. p+1 edges after sampling.
  - Aligned mode: all channels are valid N_CH edges after sampling.
- Each stalled cycle adds exactly one cycle of latency to every in-flight request.
- Back-to-back requests are supported with throughput 1 per cycle. Order is preserved per channel.
- Stall and flush in the same cycle: flush wins, and the chain is empty next cycle.
- Flush and enable_in in the same cycle: the input is dropped and state goes to IDLE.
- The chain has no overflow condition; it is a pure pipeline and never full.

## Structure
- Package lstm_sa_pkg holds:
  - the delay_state_t enum {IDLE, RUN, DRAIN}
  - an addr_w(FEATURE_BITS) constant function
  - the request struct {valid, cs, addr} used by all systolic-array delay logic
- Sub-module delay_stage: one registered request slot with hold (stall) and clear (flush) inputs and asynchronous active-low reset. It is instantiated N_CH times in a generate loop.
- The top level holds the tap mux, output masking, mode latch and FSM.

## Test plan
- Skew stream: N_CH=4, mode 0, addresses 0x00..0x09 on consecutive cycles.
  - Channel 0 shows 0x00 one edge after sampling and channel 3 shows 0x00 four edges after.
  - busy_out falls exactly 4 edges after the last input.
- Aligned mode: mode_in=1 latched while IDLE, addresses 0x05 then 0x06 → all four channels show 0x05 together after 4 edges, then 0x06.
- Stall: 2-cycle stall inserted after the third request.
  - enable_out and cs_out are all 0 during the stall, and address_out holds.
  - Every later output is delayed by exactly 2 cycles, with no loss or duplication.
- Flush with simultaneous stall and enable_in while 3 requests are in flight → next cycle all enable_out=0, busy_out=0, state IDLE, no request emerges afterwards.
- mode_in toggled during RUN → output taps unchanged until IDLE. After drain, the next stream uses the new mode and mode_out reflects it.
- reset_n pulsed low mid-stream between clock edges → all outputs 0 immediately. After release, a fresh request 0x0A appears on channel 0 after 1 edge.
